edge_map_packer: RTL
====================

Name: edge_map_packer

Overview:
- Sink at the output end of the Sobel Datapath. It consumes the 1-bit edge decision stream (Dop qualified by isReady, terminated by isEnd).
- Packs the bits into WORD_W-bit words and writes them sequentially into an output frame RAM.
- Replaces the bench-side file dump: the packed RAM image is the frame result read by the host.
- Flags completion, overruns and short frames.

Parameters:
- IMG_W, 256, pixels per row.
- IMG_H, 256, rows per frame.
- WORD_W, 8, bits packed per RAM word (power of two, 2..32).
- ADDR_W, 13, RAM word address width; must satisfy 2^ADDR_W >= ceil(IMG_W*IMG_H/WORD_W).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-low reset.
- Start  input  1  one-cycle pulse; arms capture of a new frame.
- Enable  input  1  global qualifier; when low, no input is sampled.
- Dop  input  1  edge decision bit from Datapath.
- isReady  input  1  Dop valid this cycle.
- isEnd  input  1  last pixel of frame marker from Datapath.
- MemWe  output  1  RAM write strobe, one cycle per word.
- MemAddr  output  ADDR_W  RAM word address.
- MemData  output  WORD_W  packed word.
- Busy  output  1  high in COLLECT or FLUSH.
- Done  output  1  high in DONE state.
- Overrun  output  1  sticky: valid bit arrived while not collecting.
- Short  output  1  sticky: isEnd seen before IMG_W*IMG_H bits.
- PixelCount  output  17  bits accepted this frame, saturates at 2^17-1.

Behaviour:
- Reset (Reset==0 at a rising edge): state IDLE. MemWe=0, MemAddr=0, MemData=0, Busy=0, Done=0, Overrun=0, Short=0, PixelCount=0. The shift register and bit index are cleared. Reset mid-frame abandons the partial word; no write occurs.
- Accept condition: acc = Enable & isReady & (state==COLLECT).
- Packing order: LSB-first. The bit accepted at index k of the current word lands in bit k. Unused bits of a flushed word are 0.
- States:
  - IDLE: Start -> COLLECT. Counters, bit index and MemAddr are cleared on this transition.
  - COLLECT: on acc, shift in Dop and increment the bit index and PixelCount.
    - When the bit index wraps (WORD_W bits held), the next cycle drives MemWe=1 with MemData=the completed word and the current MemAddr. MemAddr then increments after the write cycle.
    - Latency from the last accepted bit to MemWe is 1 cycle.
  - Leaving COLLECT:
    - If acc and (isEnd, or PixelCount+1 == IMG_W*IMG_H): the bit is included first.
    - If the resulting bit index is nonzero -> FLUSH; otherwise -> DONE, after the pending full-word write issues.
    - Short is set if isEnd arrives with PixelCount+1 < IMG_W*IMG_H.
    - isEnd without isReady is treated as end-of-frame with no data bit.
  - FLUSH: exactly one cycle. MemWe=1 with the zero-padded partial word, then -> DONE.
  - DONE: Done=1. Start -> COLLECT, re-armed exactly as from IDLE. Overrun and Short clear on Start.
- Overrun: set on Enable & isReady in IDLE or DONE. The bit is discarded.
- MemAddr wrap: after writing address 2^ADDR_W-1 the address wraps to 0. This is only reachable with a mis-sized ADDR_W and requires no flagging.
- Enable low in COLLECT: the state holds; a pending write strobe still issues.
- Simultaneous Start in COLLECT: ignored.
- MemWe is never high in two consecutive cycles unless consecutive words complete. Maximum rate is one word per WORD_W accepted bits.

Optional Feature:
- Macro EDGE_MAP_EDGE_COUNT_EN.
- With the macro defined:
  - Adds output EdgeCount [16:0]: count of accepted bits with Dop==1, cleared by reset and on Start, saturating at 2^17-1.
  - Adds output RowEdgeMax [$clog2(IMG_W+1)-1:0]: the largest per-row edge count seen this frame. The row boundary is every IMG_W accepted bits. It updates on the cycle after the row's last bit.
- Without the macro: neither port exists and no counting logic is synthesized.

Test Plan:
- Reset, Start, then 65536 bits with Dop = pixel index bit 0, isEnd on the last -> 8192 writes, every MemData=8'hAA, MemAddr 0..8191, Done=1, Short=0, PixelCount=65536.
- Start, 8 ones with isReady gapped every other cycle and Enable dropped 3 cycles mid-word -> single MemWe one cycle after the 8th bit, MemData=8'hFF, MemAddr=0.
- Start, 13 bits all 1, isEnd with the 13th -> writes 8'hFF at addr 0, then FLUSH writes 8'h1F at addr 1, Done=1, Short=1, PixelCount=13.
- In DONE, pulse isReady 2 times -> Overrun=1, no MemWe. Start -> Overrun=0, MemAddr restarts at 0.
- Assert Reset low after 5 bits accepted -> no write, all outputs 0. The following Start and 8 bits of 0 -> MemData=8'h00 at addr 0.
- With EDGE_MAP_EDGE_COUNT_EN, IMG_W=16, IMG_H=2: row 0 has 5 ones, row 1 has 11 ones -> EdgeCount=16, RowEdgeMax=11 at Done.

Source files
------------

// File: rtl/edge_map_packer.sv
// Packs the Sobel edge-decision bit stream LSB-first into WORD_W-bit words written to a frame RAM.
// Optional per-frame edge statistics are enabled with the EDGE_MAP_EDGE_COUNT_EN macro.
module edge_map_packer #(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned WORD_W = 8,
  parameter int unsigned ADDR_W = 13
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic                          Enable,
  input  logic                          Dop,
  input  logic                          isReady,
  input  logic                          isEnd,
  output logic                          MemWe,
  output logic [ADDR_W-1:0]             MemAddr,
  output logic [WORD_W-1:0]             MemData,
  output logic                          Busy,
  output logic                          Done,
  output logic                          Overrun,
  output logic                          Short,
`ifdef EDGE_MAP_EDGE_COUNT_EN
  output logic [16:0]                   EdgeCount,
  output logic [$clog2(IMG_W+1)-1:0]    RowEdgeMax,
`endif
  output logic [16:0]                   PixelCount
);

  localparam int unsigned IDX_W = $clog2(WORD_W);
  localparam int unsigned CNT_W = 17;
  localparam int unsigned CW1   = CNT_W + 1;
  localparam int unsigned TOTAL = IMG_W * IMG_H;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

  state_t              state, state_d;
  logic [WORD_W-1:0]   word, word_d, word_in;
  logic [IDX_W-1:0]    bit_idx, idx_d, idx_in;
  logic [CNT_W-1:0]    cnt_d;
  logic [CW1-1:0]      cnt_next;
  logic [ADDR_W-1:0]   addr_d;
  logic [WORD_W-1:0]   data_d;
  logic                we_d, busy_d, done_d, overrun_d, short_d;
  logic                acc, end_in, start_ev, word_full, frame_end;

`ifdef EDGE_MAP_EDGE_COUNT_EN
  localparam int unsigned RW = $clog2(IMG_W + 1);
  logic [CNT_W-1:0] edge_d;
  logic [RW-1:0]    row_ones, ones_d, col, col_d, rmax_d, row_sum;
`endif

  // Input qualification and the word being assembled including this cycle's bit
  always_comb begin
    start_ev  = Enable & Start;
    acc       = Enable & isReady & (state == S_COLLECT);
    end_in    = Enable & isEnd & (state == S_COLLECT);
    cnt_next  = {1'b0, PixelCount} + CW1'(acc);
    word_in   = acc ? (word | (WORD_W'(Dop) << bit_idx)) : word;
    idx_in    = bit_idx + IDX_W'(acc);
    word_full = acc & (bit_idx == IDX_W'(WORD_W - 1));
    frame_end = end_in | (acc & (cnt_next == CW1'(TOTAL)));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    word_d    = word;
    idx_d     = bit_idx;
    cnt_d     = PixelCount;
    addr_d    = MemWe ? MemAddr + ADDR_W'(1) : MemAddr;
    we_d      = 1'b0;
    data_d    = MemData;
    overrun_d = Overrun;
    short_d   = Short;
`ifdef EDGE_MAP_EDGE_COUNT_EN
    edge_d    = EdgeCount;
    ones_d    = row_ones;
    col_d     = col;
    rmax_d    = RowEdgeMax;
    row_sum   = row_ones + RW'(Dop);
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (Enable && isReady) overrun_d = 1'b1;
        if (start_ev) begin
          state_d   = S_COLLECT;
          word_d    = '0;
          idx_d     = '0;
          cnt_d     = '0;
          addr_d    = '0;
          overrun_d = 1'b0;
          short_d   = 1'b0;
`ifdef EDGE_MAP_EDGE_COUNT_EN
          edge_d    = '0;
          ones_d    = '0;
          col_d     = '0;
          rmax_d    = '0;
`endif
        end
      end
      S_COLLECT: begin
        if (acc) begin
          word_d = word_in;
          idx_d  = idx_in;
          if (PixelCount != CNT_MAX) cnt_d = PixelCount + CNT_W'(1);
`ifdef EDGE_MAP_EDGE_COUNT_EN
          if (Dop && (EdgeCount != CNT_MAX)) edge_d = EdgeCount + CNT_W'(1);
          if (col == RW'(IMG_W - 1)) begin
            if (row_sum > RowEdgeMax) rmax_d = row_sum;
            ones_d = '0;
            col_d  = '0;
          end else begin
            ones_d = row_sum;
            col_d  = col + RW'(1);
          end
`endif
        end
        if (word_full) begin
          we_d   = 1'b1;
          data_d = word_in;
          word_d = '0;
        end
        // A partial word at frame end goes out as the single FLUSH write
        if (frame_end) begin
          if (idx_in != '0) begin
            we_d    = 1'b1;
            data_d  = word_in;
            word_d  = '0;
            idx_d   = '0;
            state_d = S_FLUSH;
          end else begin
            state_d = S_DONE;
          end
          if (end_in && (cnt_next < CW1'(TOTAL))) short_d = 1'b1;
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_COLLECT) || (state_d == S_FLUSH);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= S_IDLE;
      word       <= '0;
      bit_idx    <= '0;
      PixelCount <= '0;
      MemAddr    <= '0;
      MemWe      <= 1'b0;
      MemData    <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Overrun    <= 1'b0;
      Short      <= 1'b0;
`ifdef EDGE_MAP_EDGE_COUNT_EN
      EdgeCount  <= '0;
      RowEdgeMax <= '0;
      row_ones   <= '0;
      col        <= '0;
`endif
    end else begin
      state      <= state_d;
      word       <= word_d;
      bit_idx    <= idx_d;
      PixelCount <= cnt_d;
      MemAddr    <= addr_d;
      MemWe      <= we_d;
      MemData    <= data_d;
      Busy       <= busy_d;
      Done       <= done_d;
      Overrun    <= overrun_d;
      Short      <= short_d;
`ifdef EDGE_MAP_EDGE_COUNT_EN
      EdgeCount  <= edge_d;
      RowEdgeMax <= rmax_d;
      row_ones   <= ones_d;
      col        <= col_d;
`endif
    end
  end

endmodule
